// File: rtl/count_wrap_monitor.sv
// count_wrap_monitor: watches an upstream up/down counter, detects wrap-around
// (overflow 2^WIDTH-1 -> 0 counting up, underflow 0 -> 2^WIDTH-1 counting down),
// timestamps each wrap and queues it in a small event FIFO. Also keeps a
// saturating total of wraps and a sticky drop flag for events lost to a full FIFO.
//
// Event handshake: a record is offered whenever evt_valid = 1, and it is taken
// on any rising edge where evt_valid = 1 and evt_ready = 1. evt_valid comes
// straight from the registered occupancy, never from evt_ready. While the
// record waits (valid high, ready low), evt_type and evt_stamp hold steady.
module count_wrap_monitor #(
  parameter int WIDTH     = 4,
  parameter int EVT_DEPTH = 4,
  parameter int WRAP_W    = 8,
  localparam int LVL_W    = $clog2(EVT_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  count_in,
  input  logic              up_down_in,
  input  logic              cnt_clr,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [1:0]        evt_type,
  output logic [15:0]       evt_stamp,
  output logic [WRAP_W-1:0] wrap_total,
  output logic              evt_drop,
  output logic [LVL_W-1:0]  fifo_level
);

  localparam int PTR_W = $clog2(EVT_DEPTH);
  localparam logic [WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [WIDTH-1:0] CNT_ZERO = '0;
  localparam logic [1:0] TYPE_OVF = 2'b01;
  localparam logic [1:0] TYPE_UNF = 2'b10;

  logic [WIDTH-1:0] prev_count;
  logic             prev_clr;
  logic             prev_valid;
  logic [15:0]      timestamp;

  // Each FIFO entry is {type, stamp}.
  logic [17:0]      mem [EVT_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  logic       ovf_det;
  logic       unf_det;
  logic       det;
  logic [1:0] det_type;
  logic       full;
  logic       pop;
  logic       push_ok;

  // Wrap detection: a transition only counts when neither this cycle nor the
  // previous one was an upstream clear, and only after one sample exists.
  always_comb begin
    ovf_det  = 1'b0;
    unf_det  = 1'b0;
    det_type = TYPE_OVF;
    if (prev_valid && !prev_clr && !cnt_clr) begin
      ovf_det = (prev_count == CNT_MAX) && (count_in == CNT_ZERO) && up_down_in;
      unf_det = (prev_count == CNT_ZERO) && (count_in == CNT_MAX) && !up_down_in;
    end
    if (unf_det) det_type = TYPE_UNF;
    det = ovf_det || unf_det;
  end

  // FIFO control: a full FIFO still accepts a push when the head leaves in the
  // same cycle, because the freed slot is exactly the one being written.
  always_comb begin
    full    = (fifo_level == LVL_W'(EVT_DEPTH));
    pop     = evt_valid && evt_ready;
    push_ok = det && (!full || pop);
  end

  assign evt_valid = (fifo_level != '0);
  assign evt_type  = mem[rd_ptr][17:16];
  assign evt_stamp = mem[rd_ptr][15:0];

  // Sample history of the upstream counter and the free-running timestamp.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_count <= '0;
      prev_clr   <= 1'b0;
      prev_valid <= 1'b0;
      timestamp  <= '0;
    end else begin
      prev_count <= count_in;
      prev_clr   <= cnt_clr;
      prev_valid <= 1'b1;
      timestamp  <= timestamp + 16'd1;
    end
  end

  // Event storage; contents need no reset since occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (!reset && push_ok) mem[wr_ptr] <= {det_type, timestamp};
  end

  // Pointers, occupancy, sticky drop flag and saturating wrap total.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      evt_drop   <= 1'b0;
      wrap_total <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      if (push_ok && !pop)      fifo_level <= fifo_level + LVL_W'(1);
      else if (pop && !push_ok) fifo_level <= fifo_level - LVL_W'(1);
      if (det && !push_ok) evt_drop <= 1'b1;
      if (det && (wrap_total != '1)) wrap_total <= wrap_total + WRAP_W'(1);
    end
  end

endmodule
